nnlut_arbiter: RTL and testbench

- Shares one NN-LUT activation pipeline (fixed latency, no stall) between NUM_REQ requesters, e.g. the GELU and softmax-exp producers of the op_trans stage.
- Grants one requester per cycle in round-robin order and drives the LUT input register.
- Tags every issued sample with its requester ID, then steers each LUT result back to the requester that issued it.
- Provides a flush/drain sequence and a sticky protocol-error flag.

---
 rtl/nnlut_arbiter.sv | 137 +++++++++++++
 tb/tb_nnlut_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nnlut_arbiter.sv
// Round-robin arbiter sharing one fixed-latency NN-LUT; grant->response is LUT_LAT+2 cycles.
// Grants are combinational one-hot-low; responses cannot be back-pressured.
module nnlut_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int X_WIDTH   = 8,
    parameter int RES_WIDTH = 41,
    parameter int LUT_LAT   = 2,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk_p,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_n,
    input  logic [NUM_REQ*X_WIDTH-1:0]   req_x,
    output logic [NUM_REQ-1:0]           req_ready_n,
    output logic [X_WIDTH-1:0]           lut_x,
    output logic                         lut_valid_n,
    input  logic [RES_WIDTH-1:0]         lut_res,
    input  logic                         lut_res_valid_n,
    output logic [RES_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]           rsp_valid_n,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic                         err
);

    localparam int INF_W = $clog2(LUT_LAT + 3) + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [INF_W-1:0]               inflight_q, inflight_d;
    logic [X_WIDTH-1:0]             lut_x_q, lut_x_d;
    logic                           lut_valid_n_q, lut_valid_n_d;
    logic [RES_WIDTH-1:0]           rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]             rsp_valid_n_q, rsp_valid_n_d;
    logic                           err_q, err_d;
    logic [LUT_LAT:0]               tag_vld_q, tag_vld_d;
    logic [LUT_LAT:0][ID_W-1:0]     tag_id_q, tag_id_d;

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] cand;
    logic            fin_vld;
    logic [ID_W-1:0] fin_id;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_vld     = 1'b0;
        gnt_id      = '0;
        cand        = '0;
        req_ready_n = '1;
        if (state_q == ST_RUN) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!gnt_vld && !req_valid_n[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = cand;
                end
            end
            if (gnt_vld) begin
                req_ready_n[gnt_id] = 1'b0;
            end
        end
    end

    assign fin_vld = tag_vld_q[LUT_LAT];
    assign fin_id  = tag_id_q[LUT_LAT];

    always_comb begin
        lut_x_d       = lut_x_q;
        lut_valid_n_d = ~gnt_vld;
        if (gnt_vld) begin
            lut_x_d = req_x[gnt_id*X_WIDTH +: X_WIDTH];
        end

        tag_vld_d = {tag_vld_q[LUT_LAT-1:0], gnt_vld};
        tag_id_d  = {tag_id_q[LUT_LAT-1:0], gnt_id};

        rsp_data_d    = rsp_data_q;
        rsp_valid_n_d = '1;
        if (fin_vld && !lut_res_valid_n) begin
            rsp_data_d            = lut_res;
            rsp_valid_n_d[fin_id] = 1'b0;
        end

        // Spurious result or lost result; a lost one still retires its tag.
        err_d = err_q | (!fin_vld && !lut_res_valid_n) | (fin_vld && lut_res_valid_n);

        inflight_d = inflight_q + INF_W'(gnt_vld) - INF_W'(fin_vld);
        rr_ptr_d   = gnt_vld ? gnt_id : rr_ptr_q;

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == '0 && rsp_valid_n_q == '1) state_d = ST_DONE;
            ST_DONE:  if (!flush_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            inflight_q    <= '0;
            lut_x_q       <= '0;
            lut_valid_n_q <= 1'b1;
            rsp_data_q    <= '0;
            rsp_valid_n_q <= '1;
            err_q         <= 1'b0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            lut_x_q       <= lut_x_d;
            lut_valid_n_q <= lut_valid_n_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_n_q <= rsp_valid_n_d;
            err_q         <= err_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
        end
    end

    assign lut_x       = lut_x_q;
    assign lut_valid_n = lut_valid_n_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_valid_n = rsp_valid_n_q;
    assign err         = err_q;
    assign flush_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_nnlut_arbiter.sv
// Scoreboard bench for nnlut_arbiter with a 2-cycle behavioural LUT (res = 20*x + 23).
module tb_nnlut_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int RW = 41;

    logic              clk_p = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid_n;
    logic [N*XW-1:0]   req_x;
    logic [N-1:0]      req_ready_n;
    logic [XW-1:0]     lut_x;
    logic              lut_valid_n;
    logic [RW-1:0]     lut_res;
    logic              lut_res_valid_n;
    logic [RW-1:0]     rsp_data;
    logic [N-1:0]      rsp_valid_n;
    logic              flush_req;
    logic              flush_done;
    logic              err;

    logic              spur;
    logic              drop_arm;
    logic [1:0]        m_v;
    logic [XW-1:0]     m_x0, m_x1;

    typedef struct {
        int          id;
        logic [RW-1:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    nnlut_arbiter #(.NUM_REQ(N), .X_WIDTH(XW), .RES_WIDTH(RW), .LUT_LAT(2), .ID_W(2)) dut (
        .clk_p(clk_p), .rst_n(rst_n),
        .req_valid_n(req_valid_n), .req_x(req_x), .req_ready_n(req_ready_n),
        .lut_x(lut_x), .lut_valid_n(lut_valid_n),
        .lut_res(lut_res), .lut_res_valid_n(lut_res_valid_n),
        .rsp_data(rsp_data), .rsp_valid_n(rsp_valid_n),
        .flush_req(flush_req), .flush_done(flush_done), .err(err)
    );

    always #5 clk_p = ~clk_p;
    always @(posedge clk_p) cyc <= cyc + 1;

    function automatic logic [RW-1:0] lut_f(input logic [XW-1:0] x);
        logic signed [RW-1:0] xs;
        xs = RW'($signed(x));
        return xs * 41'sd20 + 41'sd23;
    endfunction

    // Behavioural LUT: result strobe two cycles after the issue strobe.
    always @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            m_v  <= 2'b00;
            m_x0 <= '0;
            m_x1 <= '0;
        end else begin
            m_v  <= {m_v[0], ~lut_valid_n & ~drop_arm};
            m_x0 <= lut_x;
            m_x1 <= m_x0;
        end
    end
    assign lut_res_valid_n = ~(m_v[1] | spur);
    assign lut_res         = lut_f(m_x1);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_x(input int i, input logic [XW-1:0] v);
        req_x[i*XW +: XW] = v;
    endtask

    task automatic exp_grant(input int id);
        logic [N-1:0] exp_rdy;
        exp_rdy     = '1;
        exp_rdy[id] = 1'b0;
        #1;
        chk("grant", req_ready_n, exp_rdy);
        sbq.push_back('{id, lut_f(req_x[id*XW +: XW]), cyc + 4});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_p);
    endtask

    task automatic do_reset();
        @(negedge clk_p);
        rst_n       = 1'b0;
        req_valid_n = '1;
        flush_req   = 1'b0;
        spur        = 1'b0;
        drop_arm    = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk_p);
        rst_n = 1'b1;
    endtask

    task automatic wait_flush_done(input int budget);
        int n;
        n = 0;
        while (!flush_done && n < budget) begin
            @(negedge clk_p);
            n++;
        end
        chk("flush_done_reached", flush_done, 1'b1);
    endtask

    // Monitor: every response strobe is matched against the head of the scoreboard.
    initial begin
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk_p);
            if (rst_n && rsp_valid_n !== '1) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid_n, 4'hF);
                end else begin
                    e  = sbq.pop_front();
                    oh = '1;
                    oh[e.id] = 1'b0;
                    chk("rsp_id", rsp_valid_n, oh);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcyc;
        rst_n       = 1'b0;
        req_valid_n = '1;
        req_x       = '0;
        flush_req   = 1'b0;
        spur        = 1'b0;
        drop_arm    = 1'b0;
        repeat (2) @(negedge clk_p);

        chk("rst_lut_valid_n", lut_valid_n, 1'b1);
        chk("rst_lut_x", lut_x, 8'h00);
        chk("rst_rsp_valid_n", rsp_valid_n, 4'hF);
        chk("rst_rsp_data", rsp_data, 41'd0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req_ready_n", req_ready_n, 4'hF);
        rst_n = 1'b1;

        // Single request from requester 2.
        @(negedge clk_p);
        set_x(2, 8'h05);
        req_valid_n = 4'b1011;
        exp_grant(2);
        chk("single_data_is_123", lut_f(8'h05), 41'd123);
        @(negedge clk_p);
        req_valid_n = '1;
        #1;
        chk("single_lut_valid_n", lut_valid_n, 1'b0);
        chk("single_lut_x", lut_x, 8'h05);
        chk("single_no_grant", req_ready_n, 4'hF);
        idle(6);
        chk("single_sb_empty", sbq.size(), 0);

        // Round-robin over all four requesters.
        do_reset();
        set_x(0, 8'hFC); set_x(1, 8'hFF); set_x(2, 8'h02); set_x(3, 8'h05);
        req_valid_n = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk_p);
                chk("rr_lut_valid_n", lut_valid_n, 1'b0);
                chk("rr_lut_x", lut_x, req_x[((k - 1) % 4)*XW +: XW]);
            end
            exp_grant(k % 4);
        end
        @(negedge clk_p);
        req_valid_n = '1;
        chk("rr_last_lut_valid_n", lut_valid_n, 1'b0);
        chk("rr_last_lut_x", lut_x, 8'h05);
        @(negedge clk_p);
        chk("rr_idle_lut_valid_n", lut_valid_n, 1'b1);
        idle(6);
        chk("rr_sb_empty", sbq.size(), 0);

        // Wrap and skip: only requesters 1 and 3.
        do_reset();
        set_x(1, 8'h7F); set_x(3, 8'h80);
        req_valid_n = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk_p);
            exp_grant((k % 2 == 0) ? 1 : 3);
        end
        @(negedge clk_p);
        req_valid_n = '1;
        idle(6);
        chk("skip_sb_empty", sbq.size(), 0);

        // Flush during continuous traffic.
        do_reset();
        set_x(0, 8'h11); set_x(1, 8'h22); set_x(2, 8'h33); set_x(3, 8'h44);
        req_valid_n = '0;
        gcyc = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_p);
            if (k == 4) begin
                flush_req = 1'b1;
                gcyc      = cyc;
            end
            exp_grant(k % 4);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_p);
            #1;
            chk("drain_no_grant", req_ready_n, 4'hF);
            chk("drain_flush_done_low", flush_done, 1'b0);
        end
        wait_flush_done(30);
        chk("flush_done_cycle", cyc, gcyc + 6);
        chk("flush_sb_empty", sbq.size(), 0);
        flush_req = 1'b0;
        #1;
        chk("done_no_grant", req_ready_n, 4'hF);
        @(negedge clk_p);
        chk("flush_done_fell", flush_done, 1'b0);
        exp_grant(1);
        @(negedge clk_p);
        req_valid_n = '1;
        idle(6);
        chk("resume_sb_empty", sbq.size(), 0);

        // Spurious LUT result.
        do_reset();
        spur = 1'b1;
        @(negedge clk_p);
        spur = 1'b0;
        #1;
        chk("spurious_err", err, 1'b1);
        idle(5);
        chk("spurious_err_sticky", err, 1'b1);
        do_reset();
        #1;
        chk("err_cleared_by_reset", err, 1'b0);

        // Lost LUT result: error raised and the tag still retires.
        drop_arm = 1'b1;
        set_x(0, 8'h09);
        req_valid_n = 4'b1110;
        #1;
        chk("lost_grant", req_ready_n, 4'b1110);
        @(negedge clk_p);
        req_valid_n = '1;
        idle(5);
        chk("lost_err", err, 1'b1);
        flush_req = 1'b1;
        wait_flush_done(20);
        flush_req = 1'b0;
        drop_arm  = 1'b0;
        @(negedge clk_p);

        // Asynchronous reset with three samples in flight.
        do_reset();
        set_x(0, 8'h01); set_x(1, 8'h02); set_x(2, 8'h03); set_x(3, 8'h04);
        req_valid_n = '0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk_p);
            exp_grant(k);
        end
        @(negedge clk_p);
        req_valid_n = '1;
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("arst_lut_valid_n", lut_valid_n, 1'b1);
        chk("arst_lut_x", lut_x, 8'h00);
        chk("arst_rsp_valid_n", rsp_valid_n, 4'hF);
        chk("arst_rsp_data", rsp_data, 41'd0);
        chk("arst_err", err, 1'b0);
        repeat (2) @(negedge clk_p);
        rst_n = 1'b1;
        idle(6);
        chk("arst_no_err_after", err, 1'b0);
        req_valid_n = '0;
        exp_grant(0);
        @(negedge clk_p);
        req_valid_n = '1;
        idle(8);
        chk("final_sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
